uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte FIFO and launch controller that sits directly upstream of the UART transmitter. It accepts bytes from a producer at any rate up to one per clock. It buffers them and hands them to the transmitter one at a time using the transmitter's DV/Byte command interface, waiting for each byte's done pulse before launching the next. The result is back-to-back serial output with no software pacing.

## Interface
Parameters:
- DEPTH, 16, number of byte entries; power of two, 2..256
- CNT_W, $clog2(DEPTH)+1, width of o_Count (derived; not overridden)

Ports:
- i_Clock  input  1  system clock; all logic on rising edge
- i_Rst_L  input  1  asynchronous, active-low reset
- i_Wr_DV  input  1  write strobe; one byte per cycle while high
- i_Wr_Byte  input  8  write data, sampled when i_Wr_DV=1
- o_Full  output  1  FIFO holds DEPTH bytes
- o_Empty  output  1  FIFO holds 0 bytes
- o_Count  output  CNT_W  bytes currently stored (excludes the byte in flight)
- o_Overflow  output  1  one-cycle pulse: a write was dropped because the FIFO was full
- o_TX_DV  output  1  one-cycle launch pulse to the transmitter's DV input
- o_TX_Byte  output  8  byte to transmit; stable from launch until done
- i_TX_Active  input  1  transmitter busy flag
- i_TX_Done  input  1  transmitter one-cycle done pulse
- o_Busy  output  1  a byte is launched and not yet done

## Operation
- Storage: DEPTH x 8 circular buffer with a write pointer, a read pointer and a count register. Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Write: if i_Wr_DV=1 and o_Full=0, store i_Wr_Byte at the write pointer and advance the write pointer.
- Write while o_Full=1: drop the byte. Pointers and count are unchanged. o_Overflow=1 on the following cycle.
- Pop: occurs only on launch. The head byte is registered into o_TX_Byte and the read pointer advances.
- Simultaneous write and pop:
  - Not full: both take effect and count is unchanged.
  - Full: the write is dropped even though a pop happens in the same cycle. Full is judged on the registered count.
- Launch FSM, 3 states, reset state IDLE:
  - IDLE: if o_Empty=0 and i_TX_Active=0, pop, drive o_TX_DV=1 and go to LAUNCH. Otherwise stay.
  - LAUNCH: o_TX_DV=0; go to BUSY unconditionally. This cycle gives the transmitter time to raise i_TX_Active.
  - BUSY: wait for i_TX_Done=1, then go to IDLE. A done pulse seen in IDLE or LAUNCH is ignored.
- o_Busy=1 in LAUNCH and BUSY.
- o_TX_Byte holds its value until the next launch.
- Reset mid-operation clears the FIFO contents and the FSM state. A transmission already in progress in the transmitter is not aborted by this block. That frame's later done pulse arrives in IDLE and is ignored.

## Timing
- Reset values: o_Full=0, o_Empty=1, o_Count=0, o_Overflow=0, o_TX_DV=0, o_TX_Byte=8'h00, o_Busy=0. Both pointers are 0 and the FSM is in IDLE.
- All outputs are registered. Status flags reflect writes and pops at the edge after the one that samples them.
- Write-to-launch latency, empty FIFO and idle transmitter:
  - i_Wr_DV sampled at edge N; o_Empty falls after edge N.
  - o_TX_DV is high for exactly one cycle, after edge N+1, with o_TX_Byte valid in that same cycle.
- Done-to-next-launch latency: i_TX_Done sampled at edge M returns the FSM to IDLE. The next o_TX_DV rises after edge M+1 if the FIFO is non-empty and i_TX_Active=0.
- o_TX_DV is never high on two consecutive cycles. At most one launch is outstanding at any time.
- Throughput: one byte per transmitter frame plus 2 clocks of handoff.

## Test plan
- Reset checks:
  - Stimulus: hold i_Rst_L=0 for 3 cycles mid-burst.
  - Required: all outputs at their reset values asynchronously; after release, no o_TX_DV until a new write.
- Single byte:
  - Stimulus: write 8'h3F with the transmitter model idle.
  - Required: o_TX_DV pulses one cycle with o_TX_Byte=8'h3F exactly 2 edges after the write. o_Busy stays high until the model's i_TX_Done. The looped-back receiver outputs 8'h3F.
- Burst ordering:
  - Stimulus: write 8'h01..8'h05 on 5 consecutive cycles.
  - Required: exactly 5 launches in order 01,02,03,04,05. Each launch occurs only after the previous done. o_Count peaks at 4.
- Full and overflow:
  - Stimulus: with DEPTH=16 and i_TX_Active held high (no launch), write 17 bytes.
  - Required: o_Full=1 after the 16th write, and o_Overflow pulses once for the 17th. The dropped byte never appears; the transmitted order is bytes 1..16.
- Simultaneous write and pop with pointer wrap:
  - Stimulus: keep o_Count near 1 while streaming 40 bytes through a DEPTH=16 FIFO, so that writes land in launch cycles and the pointers wrap at least twice.
  - Required: o_Count is unchanged in each write+pop cycle, no data is lost, order is preserved, and o_Overflow stays 0.
- Spurious done:
  - Stimulus: pulse i_TX_Done while in IDLE with the FIFO empty, then write 8'hA5.
  - Required: no launch from the stray pulse. 8'hA5 launches normally with standard latency.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: buffers producer writes and launches
// one byte at a time over the DV/Byte interface, waiting for each done pulse.
module uart_tx_fifo #(
    parameter  int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             i_Clock,
    input  logic             i_Rst_L,
    input  logic             i_Wr_DV,
    input  logic [7:0]       i_Wr_Byte,
    output logic             o_Full,
    output logic             o_Empty,
    output logic [CNT_W-1:0] o_Count,
    output logic             o_Overflow,
    output logic             o_TX_DV,
    output logic [7:0]       o_TX_Byte,
    input  logic             i_TX_Active,
    input  logic             i_TX_Done,
    output logic             o_Busy
);
    localparam int PTR_W = $clog2(DEPTH);

    // Handshake: o_TX_DV is a one-cycle launch with o_TX_Byte valid in the same
    // cycle; no new launch until i_TX_Done has been seen in S_BUSY.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_BUSY   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ovf_q, ovf_d;
    logic             tx_dv_q, tx_dv_d;
    logic             busy_q, busy_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic [7:0]       mem_q [DEPTH];
    logic             wr_en;
    logic             pop;

    always_comb begin
        // Full is judged on the registered flag, so a pop in the same cycle
        // does not rescue a write into a full buffer.
        wr_en     = i_Wr_DV && !full_q;
        pop       = (state_q == S_IDLE) && !empty_q && !i_TX_Active;
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        tx_byte_d = tx_byte_q;

        case (state_q)
            S_IDLE:   if (pop) state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_BUSY;
            S_BUSY:   if (i_TX_Done) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            tx_byte_d = mem_q[rd_ptr_q];
        end

        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
        ovf_d   = i_Wr_DV && full_q;
        tx_dv_d = pop;
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            tx_dv_q   <= 1'b0;
            busy_q    <= 1'b0;
            tx_byte_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
            tx_dv_q   <= tx_dv_d;
            busy_q    <= busy_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    // Storage needs no reset: the cleared count makes stale entries unreachable.
    always_ff @(posedge i_Clock) begin
        if (wr_en) mem_q[wr_ptr_q] <= i_Wr_Byte;
    end

    assign o_Full     = full_q;
    assign o_Empty    = empty_q;
    assign o_Count    = count_q;
    assign o_Overflow = ovf_q;
    assign o_TX_DV    = tx_dv_q;
    assign o_TX_Byte  = tx_byte_q;
    assign o_Busy     = busy_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: transmitter model, queue-based reference model with
// per-cycle comparison, and directed plus randomized scenario tasks.
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_dv = 1'b0;
    logic [7:0]       wr_byte = 8'h00;
    logic             model_active = 1'b0;
    logic             hold_active = 1'b0;
    logic             model_done = 1'b0;
    logic             stray_done = 1'b0;
    logic             tx_active;
    logic             tx_done;
    logic             o_Full, o_Empty, o_Overflow, o_TX_DV, o_Busy;
    logic [CNT_W-1:0] o_Count;
    logic [7:0]       o_TX_Byte;

    assign tx_active = model_active | hold_active;
    assign tx_done   = model_done | stray_done;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .i_Clock    (clk),
        .i_Rst_L    (rst_n),
        .i_Wr_DV    (wr_dv),
        .i_Wr_Byte  (wr_byte),
        .o_Full     (o_Full),
        .o_Empty    (o_Empty),
        .o_Count    (o_Count),
        .o_Overflow (o_Overflow),
        .o_TX_DV    (o_TX_DV),
        .o_TX_Byte  (o_TX_Byte),
        .i_TX_Active(tx_active),
        .i_TX_Done  (tx_done),
        .o_Busy     (o_Busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail = 0;
    int         launch_cnt = 0;
    bit         chk_en = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    // transmitter model: busy for a random frame length after each launch
    bit         tx_busy_m = 1'b0;
    int         remain = 0;
    logic [7:0] tx_e;
    initial forever begin
        @(posedge clk);
        #2;
        model_done = 1'b0;
        if (o_TX_DV) begin
            launch_cnt++;
            got_q.push_back(o_TX_Byte);
            n_tests++;
            if (tx_busy_m) begin
                n_fail++;
                $display("FAIL launch_overlap: got launch of %h while frame busy, required none", o_TX_Byte);
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: got launch of %h, required no launch (queue empty)", o_TX_Byte);
            end else begin
                tx_e = exp_q.pop_front();
                if (o_TX_Byte !== tx_e) begin
                    n_fail++;
                    $display("FAIL scoreboard: got byte %h, required %h", o_TX_Byte, tx_e);
                end
            end
            tx_busy_m    = 1'b1;
            model_active = 1'b1;
            remain       = $urandom_range(2, 6);
        end else if (tx_busy_m) begin
            remain--;
            if (remain == 0) begin
                model_done   = 1'b1;
                model_active = 1'b0;
                tx_busy_m    = 1'b0;
            end
        end
    end

    // reference model: byte queue plus one-outstanding-launch bookkeeping
    logic [7:0] m_q[$];
    bit         m_out = 1'b0;
    int         m_age = 0;
    bit         m_pop, m_acc;
    bit         e_ovf = 1'b0;
    bit         e_dv = 1'b0;
    logic [7:0] e_byte = 8'h00;
    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            exp_q.delete();
            m_out  = 1'b0;
            e_ovf  = 1'b0;
            e_dv   = 1'b0;
            e_byte = 8'h00;
        end else begin
            m_pop = !m_out && (m_q.size() > 0) && !tx_active;
            m_acc = wr_dv && (m_q.size() < DEPTH);
            e_ovf = wr_dv && !m_acc;
            e_dv  = m_pop;
            if (m_out) begin
                if (m_age >= 1 && tx_done) m_out = 1'b0;
                m_age++;
            end
            if (m_pop) begin
                e_byte = m_q.pop_front();
                m_out  = 1'b1;
                m_age  = 0;
            end
            if (m_acc) begin
                m_q.push_back(wr_byte);
                exp_q.push_back(wr_byte);
            end
        end
    end

    logic [CNT_W+12:0] act_v, exp_v;
    initial forever begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            n_tests++;
            act_v = {o_Count, o_Full, o_Empty, o_Overflow, o_TX_DV, o_Busy, o_TX_Byte};
            exp_v = {CNT_W'(m_q.size()), m_q.size() == DEPTH, m_q.size() == 0,
                     e_ovf, e_dv, m_out, e_byte};
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL lockstep t=%0t: got {cnt,full,empty,ovf,dv,busy,byte}=%h, required %h",
                         $time, act_v, exp_v);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_dv   = 1'b1;
        wr_byte = b;
        step();
        wr_dv   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!o_Busy && !tx_busy_m && o_Empty && !tx_active && !model_done) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_idle_timeout: got busy=%b empty=%b, required idle within 600 cycles",
                     name, o_Busy, o_Empty);
        end
    endtask

    // scenarios
    task automatic test_reset();
        step();
        step();
        n_tests++;
        if (o_Count !== '0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d, required 0", o_Count);
        end
        n_tests++;
        if (o_Full !== 1'b0 || o_Empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_flags: got full=%b empty=%b, required 0/1", o_Full, o_Empty);
        end
        n_tests++;
        if ({o_Overflow, o_TX_DV, o_Busy, o_TX_Byte} !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got ovf=%b dv=%b busy=%b byte=%h, required all 0",
                     o_Overflow, o_TX_DV, o_Busy, o_TX_Byte);
        end
        rst_n  = 1'b1;
        chk_en = 1'b1;
        step();
    endtask

    task automatic test_single(input logic [7:0] b, input string name);
        bit busy_ok = 1'b1;
        bit seen = 1'b0;
        wait_idle(name);
        got_q.delete();
        write_byte(b);
        n_tests++;
        if (o_Empty !== 1'b0 || o_TX_DV !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_after_write: got empty=%b dv=%b, required 0/0", name, o_Empty, o_TX_DV);
        end
        step();
        n_tests++;
        if ({o_TX_DV, o_TX_Byte} !== {1'b1, b}) begin
            n_fail++;
            $display("FAIL %s_launch: got dv=%b byte=%h, required 1/%h", name, o_TX_DV, o_TX_Byte, b);
        end
        step();
        n_tests++;
        if (o_TX_DV !== 1'b0 || o_Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_dv_width: got dv=%b busy=%b, required 0/1", name, o_TX_DV, o_Busy);
        end
        for (int i = 0; i < 50; i++) begin
            step();
            if (model_done) begin
                seen = 1'b1;
                break;
            end
            if (o_Busy !== 1'b1) busy_ok = 1'b0;
        end
        n_tests++;
        if (!seen || !busy_ok || o_Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy: got done_seen=%b held=%b busy_after_done=%b, required 1/1/0",
                     name, seen, busy_ok, o_Busy);
        end
        n_tests++;
        if (got_q.size() != 1 || got_q[0] !== b) begin
            n_fail++;
            $display("FAIL %s_received: got %0d bytes (first %h), required 1 byte %h",
                     name, got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, b);
        end
    endtask

    task automatic test_burst();
        int peak = 0;
        bit order_ok = 1'b1;
        wait_idle("burst");
        got_q.delete();
        for (int i = 1; i <= 5; i++) begin
            wr_dv   = 1'b1;
            wr_byte = 8'(i);
            step();
            if (int'(o_Count) > peak) peak = int'(o_Count);
        end
        wr_dv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (int'(o_Count) > peak) peak = int'(o_Count);
        end
        wait_idle("burst");
        n_tests++;
        if (got_q.size() != 5) begin
            n_fail++;
            $display("FAIL burst_launches: got %0d, required 5", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 5; i++)
            if (got_q[i] !== 8'(i + 1)) order_ok = 1'b0;
        n_tests++;
        if (!order_ok) begin
            n_fail++;
            $display("FAIL burst_order: got out-of-order bytes, required 01..05");
        end
        n_tests++;
        if (peak != 4) begin
            n_fail++;
            $display("FAIL burst_peak: got %0d, required 4", peak);
        end
    endtask

    task automatic test_full_overflow();
        int ovf_cnt = 0;
        bit order_ok = 1'b1;
        wait_idle("full");
        got_q.delete();
        hold_active = 1'b1;
        step();
        for (int i = 1; i <= 16; i++) begin
            write_byte(8'(i));
            if (o_Overflow) ovf_cnt++;
        end
        n_tests++;
        if (o_Full !== 1'b1 || o_Count !== CNT_W'(16)) begin
            n_fail++;
            $display("FAIL full_after_16: got full=%b count=%0d, required 1/16", o_Full, o_Count);
        end
        write_byte(8'hEE);
        n_tests++;
        if (o_Overflow !== 1'b1 || o_Count !== CNT_W'(16)) begin
            n_fail++;
            $display("FAIL overflow_pulse: got ovf=%b count=%0d, required 1/16", o_Overflow, o_Count);
        end
        ovf_cnt++;
        step();
        if (o_Overflow) ovf_cnt++;
        n_tests++;
        if (ovf_cnt != 1) begin
            n_fail++;
            $display("FAIL overflow_once: got %0d pulse-cycles, required 1", ovf_cnt);
        end
        hold_active = 1'b0;
        wait_idle("full");
        n_tests++;
        if (got_q.size() != 16) begin
            n_fail++;
            $display("FAIL full_drain_count: got %0d, required 16", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 16; i++)
            if (got_q[i] !== 8'(i + 1)) order_ok = 1'b0;
        n_tests++;
        if (!order_ok) begin
            n_fail++;
            $display("FAIL full_drain_order: got wrong or dropped-byte sequence, required 1..16");
        end
    endtask

    task automatic test_wrap_stream();
        logic [7:0]       sent[$];
        logic [CNT_W-1:0] pc;
        bit               do_pop, do_wr;
        bit               ovf_seen = 1'b0;
        bit               data_ok = 1'b1;
        int               coinc = 0;
        wait_idle("wrap");
        got_q.delete();
        for (int cyc = 0; cyc < 2000 && sent.size() < 40; cyc++) begin
            do_pop = !o_Busy && !o_Empty && !tx_active;
            do_wr  = do_pop || o_Empty;
            wr_dv  = do_wr;
            if (do_wr) begin
                wr_byte = 8'($urandom);
                sent.push_back(wr_byte);
            end
            pc = o_Count;
            step();
            if (o_Overflow) ovf_seen = 1'b1;
            if (do_wr && do_pop) begin
                coinc++;
                n_tests++;
                if (o_Count !== pc || o_TX_DV !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wrap_count_hold: got count=%0d dv=%b, required count=%0d dv=1",
                             o_Count, o_TX_DV, pc);
                end
            end
        end
        wr_dv = 1'b0;
        wait_idle("wrap");
        n_tests++;
        if (coinc < 30 || ovf_seen) begin
            n_fail++;
            $display("FAIL wrap_stream: got %0d write+pop cycles ovf=%b, required >=30 and 0",
                     coinc, ovf_seen);
        end
        if (got_q.size() != sent.size()) data_ok = 1'b0;
        for (int i = 0; i < got_q.size() && i < sent.size(); i++)
            if (got_q[i] !== sent[i]) data_ok = 1'b0;
        n_tests++;
        if (!data_ok) begin
            n_fail++;
            $display("FAIL wrap_data: got %0d bytes, required %0d bytes in send order",
                     got_q.size(), sent.size());
        end
    endtask

    task automatic test_spurious_done();
        int base;
        bit quiet = 1'b1;
        wait_idle("spurious");
        base = launch_cnt;
        stray_done = 1'b1;
        step();
        stray_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (o_TX_DV || o_Busy) quiet = 1'b0;
        end
        n_tests++;
        if (!quiet || launch_cnt != base) begin
            n_fail++;
            $display("FAIL spurious_done: got %0d launches quiet=%b, required 0 and 1",
                     launch_cnt - base, quiet);
        end
        test_single(8'hA5, "after_stray");
    endtask

    task automatic test_reset_mid();
        int base;
        bit quiet = 1'b1;
        wait_idle("rst_mid");
        for (int i = 0; i < 6; i++) write_byte(8'($urandom));
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({o_Full, o_Empty, o_Count, o_Overflow, o_TX_DV, o_TX_Byte, o_Busy} !==
            {1'b0, 1'b1, CNT_W'(0), 1'b0, 1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async: got full=%b empty=%b cnt=%0d ovf=%b dv=%b byte=%h busy=%b, required reset values",
                     o_Full, o_Empty, o_Count, o_Overflow, o_TX_DV, o_TX_Byte, o_Busy);
        end
        step();
        step();
        step();
        rst_n = 1'b1;
        base = launch_cnt;
        for (int i = 0; i < 30; i++) begin
            step();
            if (o_TX_DV || o_Busy) quiet = 1'b0;
        end
        n_tests++;
        if (!quiet || launch_cnt != base) begin
            n_fail++;
            $display("FAIL reset_no_launch: got %0d launches quiet=%b, required 0 and 1",
                     launch_cnt - base, quiet);
        end
        test_single(8'h5A, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            wr_dv   = ($urandom_range(0, 99) < 45);
            wr_byte = 8'($urandom);
            step();
        end
        wr_dv = 1'b0;
        wait_idle("random");
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: got %0d accepted bytes never launched, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single(8'h3F, "single");
        test_burst();
        test_full_overflow();
        test_wrap_stream();
        test_spurious_done();
        test_reset_mid();
        test_random();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
